// File: rtl/bridge_ahb_slave_if.sv
// AHB-side front end of the AHB2APB bridge.
// Qualifies AHB transfers, pipelines the accepted address and tracks burst
// addresses. It also decodes the APB slave target and returns a two-cycle
// ERROR response for unmapped addresses or illegal sizes.
module bridge_ahb_slave_if #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] TIMER_BASE = 32'h8000_0000,
  parameter logic [WIDTH-1:0] INTC_BASE  = 32'h8000_1000,
  parameter logic [WIDTH-1:0] RPC_BASE   = 32'h8000_2000,
  parameter logic [WIDTH-1:0] SLV4_BASE  = 32'h8000_3000,
  parameter logic [WIDTH-1:0] REGION_SZ  = 32'h0000_1000
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             HSEL,
  input  logic             HREADY_IN,
  input  logic [1:0]       HTRANS,
  input  logic             HWRITE,
  input  logic [2:0]       HSIZE,
  input  logic [2:0]       HBURST,
  input  logic [WIDTH-1:0] HADDR,
  output logic             valid,
  output logic [WIDTH-1:0] HADDR_REG_D1,
  output logic [WIDTH-1:0] HADDR_REG_D2,
  output logic [WIDTH-1:0] HADDR_REG_D3,
  output logic [WIDTH-1:0] INC_ADDR,
  output logic             flag_timer,
  output logic             flag_interruptc,
  output logic             flag_remap_pause_controller,
  output logic             flag_slave4,
  output logic             HRESP,
  output logic             HREADY_ERR
);

  localparam logic [WIDTH-1:0] REGION_MASK = ~(REGION_SZ - WIDTH'(1));

  typedef enum logic [1:0] {ST_OKAY, ST_ERR1, ST_ERR2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] d1_q, d1_d, d2_q, d3_q;
  logic [WIDTH-1:0] trk_q, trk_d;
  logic [2:0]       burst_q, burst_d;
  logic [3:0]       flags_q, flags_d;
  logic [3:0]       hit;
  logic             req, ok, accept, err_req;

  // Direction does not affect address qualification or burst tracking.
  logic unused_hwrite;
  assign unused_hwrite = HWRITE;

  // Next burst address: linear increment, or wrap inside an n*size boundary.
  function automatic logic [WIDTH-1:0] next_addr(input logic [WIDTH-1:0] a,
                                                 input logic [2:0]       size,
                                                 input logic [2:0]       burst);
    logic [WIDTH-1:0] sz, inc, wb;
    sz  = WIDTH'(1) << size;
    inc = a + sz;
    case (burst)
      3'b010:  wb = sz << 2;
      3'b100:  wb = sz << 3;
      3'b110:  wb = sz << 4;
      default: wb = '0;
    endcase
    if (wb == '0) return inc;
    return (a & ~(wb - WIDTH'(1))) | (inc & (wb - WIDTH'(1)));
  endfunction

  // Region decode and transfer qualification for the current address phase.
  always_comb begin
    hit[0]  = (HADDR & REGION_MASK) == TIMER_BASE;
    hit[1]  = (HADDR & REGION_MASK) == INTC_BASE;
    hit[2]  = (HADDR & REGION_MASK) == RPC_BASE;
    hit[3]  = (HADDR & REGION_MASK) == SLV4_BASE;
    req     = HSEL & HREADY_IN & HTRANS[1];
    ok      = (|hit) & (HSIZE <= 3'd2);
    // Nothing is sampled while the first ERROR cycle stalls the bus.
    accept  = req & ok & (state_q != ST_ERR1);
    err_req = req & ~ok & (state_q != ST_ERR1);
    valid   = accept;
  end

  // Next values for address pipe, flags and burst tracker.
  always_comb begin
    d1_d    = d1_q;
    flags_d = flags_q;
    trk_d   = trk_q;
    burst_d = burst_q;
    if (accept) begin
      d1_d    = HADDR;
      flags_d = hit;
      if (HTRANS[0]) begin
        trk_d = next_addr(trk_q, HSIZE, burst_q);
      end else begin
        trk_d   = HADDR;
        burst_d = HBURST;
      end
    end
  end

  // Datapath registers; D2/D3 shift every cycle regardless of accept.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      d1_q    <= '0;
      d2_q    <= '0;
      d3_q    <= '0;
      trk_q   <= '0;
      burst_q <= '0;
      flags_q <= '0;
    end else begin
      d1_q    <= d1_d;
      d2_q    <= d1_q;
      d3_q    <= d2_q;
      trk_q   <= trk_d;
      burst_q <= burst_d;
      flags_q <= flags_d;
    end
  end

  // Error FSM state register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= ST_OKAY;
    else          state_q <= state_d;
  end

  // Error FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OKAY: state_d = err_req ? ST_ERR1 : ST_OKAY;
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = err_req ? ST_ERR1 : ST_OKAY;
      default: state_d = ST_OKAY;
    endcase
  end

  // Error FSM outputs: ERROR held two cycles, HREADY low only in the first.
  always_comb begin
    HRESP      = (state_q != ST_OKAY);
    HREADY_ERR = (state_q != ST_ERR1);
  end

  assign HADDR_REG_D1                = d1_q;
  assign HADDR_REG_D2                = d2_q;
  assign HADDR_REG_D3                = d3_q;
  assign INC_ADDR                    = trk_q;
  assign flag_timer                  = flags_q[0];
  assign flag_interruptc             = flags_q[1];
  assign flag_remap_pause_controller = flags_q[2];
  assign flag_slave4                 = flags_q[3];

endmodule

// File: tb/tb_bridge_ahb_slave_if.sv
// Directed testbench for bridge_ahb_slave_if.
module tb_bridge_ahb_slave_if;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL, HREADY_IN, HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [31:0] HADDR;
  logic        valid, HRESP, HREADY_ERR;
  logic [31:0] HADDR_REG_D1, HADDR_REG_D2, HADDR_REG_D3, INC_ADDR;
  logic        flag_timer, flag_interruptc, flag_remap_pause_controller, flag_slave4;
  logic [3:0]  flags;

  int n_run  = 0;
  int n_fail = 0;

  assign flags = {flag_slave4, flag_remap_pause_controller, flag_interruptc, flag_timer};

  bridge_ahb_slave_if dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY_IN(HREADY_IN),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HADDR(HADDR),
    .valid(valid), .HADDR_REG_D1(HADDR_REG_D1), .HADDR_REG_D2(HADDR_REG_D2),
    .HADDR_REG_D3(HADDR_REG_D3), .INC_ADDR(INC_ADDR), .flag_timer(flag_timer),
    .flag_interruptc(flag_interruptc),
    .flag_remap_pause_controller(flag_remap_pause_controller),
    .flag_slave4(flag_slave4), .HRESP(HRESP), .HREADY_ERR(HREADY_ERR)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input logic sel, input logic [1:0] trans, input logic [2:0] size,
                       input logic [2:0] burst, input logic [31:0] addr);
    HSEL = sel; HREADY_IN = 1'b1; HTRANS = trans; HSIZE = size;
    HBURST = burst; HADDR = addr; HWRITE = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 3'd2, 3'd0, 32'h0);
  endtask

  task automatic test_reset();
    idle();
    HRESETn = 1'b0;
    #2;
    n_run++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", valid); end
    n_run++; if ({HADDR_REG_D1, HADDR_REG_D2, HADDR_REG_D3} !== 96'h0) begin n_fail++;
      $display("FAIL reset_dregs got %h %h %h exp 0", HADDR_REG_D1, HADDR_REG_D2, HADDR_REG_D3); end
    n_run++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b exp 0000", flags); end
    n_run++; if (INC_ADDR !== 32'h0) begin n_fail++; $display("FAIL reset_inc got %h exp 0", INC_ADDR); end
    n_run++; if ({HRESP, HREADY_ERR} !== 2'b01) begin n_fail++;
      $display("FAIL reset_resp got %b%b exp 01", HRESP, HREADY_ERR); end
    tick();
    HRESETn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    drive(1'b1, 2'b10, 3'd2, 3'd0, 32'h8000_0010);
    HWRITE = 1'b1;
    #1;
    n_run++; if (valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b exp 1", valid); end
    tick();
    idle();
    n_run++; if (HADDR_REG_D1 !== 32'h8000_0010) begin n_fail++;
      $display("FAIL single_d1 got %h exp 80000010", HADDR_REG_D1); end
    n_run++; if (flags !== 4'b0001) begin n_fail++; $display("FAIL single_flags got %b exp 0001", flags); end
    n_run++; if (HADDR_REG_D3 !== 32'h0) begin n_fail++; $display("FAIL single_d3_early got %h exp 0", HADDR_REG_D3); end
    tick();
    n_run++; if (HADDR_REG_D2 !== 32'h8000_0010) begin n_fail++;
      $display("FAIL single_d2 got %h exp 80000010", HADDR_REG_D2); end
    tick();
    n_run++; if (HADDR_REG_D3 !== 32'h8000_0010) begin n_fail++;
      $display("FAIL single_d3 got %h exp 80000010", HADDR_REG_D3); end
    n_run++; if (valid !== 1'b0) begin n_fail++; $display("FAIL single_idle_valid got %b exp 0", valid); end
  endtask

  task automatic test_incr4();
    logic [31:0] exp_inc [4] = '{32'h8000_1000, 32'h8000_1004, 32'h8000_1008, 32'h8000_100C};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, (i == 0) ? 2'b10 : 2'b11, 3'd2, 3'b011, exp_inc[i]);
      #1;
      n_run++; if (valid !== 1'b1) begin n_fail++; $display("FAIL incr4_valid[%0d] got %b exp 1", i, valid); end
      tick();
      n_run++; if (INC_ADDR !== exp_inc[i]) begin n_fail++;
        $display("FAIL incr4_inc[%0d] got %h exp %h", i, INC_ADDR, exp_inc[i]); end
      n_run++; if (flags !== 4'b0010) begin n_fail++; $display("FAIL incr4_flags[%0d] got %b exp 0010", i, flags); end
    end
    n_run++; if (HADDR_REG_D2 !== 32'h8000_1008) begin n_fail++;
      $display("FAIL incr4_d2 got %h exp 80001008", HADDR_REG_D2); end
    idle();
  endtask

  task automatic test_wrap4_busy();
    logic [1:0]  tr   [5] = '{2'b10, 2'b11, 2'b01, 2'b11, 2'b11};
    logic [31:0] addr [5] = '{32'h8000_2008, 32'h8000_200C, 32'h8000_200C, 32'h8000_2000, 32'h8000_2004};
    logic [31:0] exp  [5] = '{32'h8000_2008, 32'h8000_200C, 32'h8000_200C, 32'h8000_2000, 32'h8000_2004};
    logic        ev   [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, tr[i], 3'd2, 3'b010, addr[i]);
      #1;
      n_run++; if (valid !== ev[i]) begin n_fail++; $display("FAIL wrap4_valid[%0d] got %b exp %b", i, valid, ev[i]); end
      tick();
      n_run++; if (INC_ADDR !== exp[i]) begin n_fail++;
        $display("FAIL wrap4_inc[%0d] got %h exp %h", i, INC_ADDR, exp[i]); end
    end
    n_run++; if (flags !== 4'b0100) begin n_fail++; $display("FAIL wrap4_flags got %b exp 0100", flags); end
    idle();
  endtask

  task automatic test_error();
    drive(1'b1, 2'b10, 3'd2, 3'd0, 32'h9000_0000);
    #1;
    n_run++; if (valid !== 1'b0) begin n_fail++; $display("FAIL err_valid got %b exp 0", valid); end
    tick();
    idle();
    n_run++; if ({HRESP, HREADY_ERR} !== 2'b10) begin n_fail++;
      $display("FAIL err_cycle1 got %b%b exp 10", HRESP, HREADY_ERR); end
    tick();
    n_run++; if ({HRESP, HREADY_ERR} !== 2'b11) begin n_fail++;
      $display("FAIL err_cycle2 got %b%b exp 11", HRESP, HREADY_ERR); end
    tick();
    n_run++; if ({HRESP, HREADY_ERR} !== 2'b01) begin n_fail++;
      $display("FAIL err_okay got %b%b exp 01", HRESP, HREADY_ERR); end
    n_run++; if (flags !== 4'b0100) begin n_fail++; $display("FAIL err_flags got %b exp 0100", flags); end
    n_run++; if (HADDR_REG_D1 !== 32'h8000_2004) begin n_fail++;
      $display("FAIL err_d1 got %h exp 80002004", HADDR_REG_D1); end
  endtask

  task automatic test_err_back_to_back();
    // Illegal size to a mapped address must also error.
    drive(1'b1, 2'b10, 3'd3, 3'd0, 32'h8000_3000);
    #1;
    n_run++; if (valid !== 1'b0) begin n_fail++; $display("FAIL size_valid got %b exp 0", valid); end
    tick();
    n_run++; if ({HRESP, HREADY_ERR} !== 2'b10) begin n_fail++;
      $display("FAIL size_err1 got %b%b exp 10", HRESP, HREADY_ERR); end
    // Mapped request during the stall cycle is not taken.
    drive(1'b1, 2'b10, 3'd2, 3'd0, 32'h8000_3000);
    #1;
    n_run++; if (valid !== 1'b0) begin n_fail++; $display("FAIL err1_forced got %b exp 0", valid); end
    tick();
    n_run++; if ({HRESP, HREADY_ERR} !== 2'b11) begin n_fail++;
      $display("FAIL size_err2 got %b%b exp 11", HRESP, HREADY_ERR); end
    n_run++; if (HADDR_REG_D1 !== 32'h8000_2004) begin n_fail++;
      $display("FAIL err1_noaccept got %h exp 80002004", HADDR_REG_D1); end
    // Mapped transfer in the second error cycle is accepted.
    drive(1'b1, 2'b10, 3'd2, 3'd0, 32'h8000_3004);
    #1;
    n_run++; if (valid !== 1'b1) begin n_fail++; $display("FAIL err2_valid got %b exp 1", valid); end
    tick();
    n_run++; if (flags !== 4'b1000) begin n_fail++; $display("FAIL err2_flags got %b exp 1000", flags); end
    n_run++; if ({HRESP, HREADY_ERR} !== 2'b01) begin n_fail++;
      $display("FAIL err2_okay got %b%b exp 01", HRESP, HREADY_ERR); end
    // Unmapped in ERR2 restarts the error sequence.
    drive(1'b1, 2'b10, 3'd2, 3'd0, 32'h0000_0100);
    tick();
    idle();
    tick();
    drive(1'b1, 2'b10, 3'd2, 3'd0, 32'h0000_0200);
    tick();
    idle();
    n_run++; if ({HRESP, HREADY_ERR} !== 2'b10) begin n_fail++;
      $display("FAIL err_b2b got %b%b exp 10", HRESP, HREADY_ERR); end
    tick();
    tick();
    n_run++; if ({HRESP, HREADY_ERR} !== 2'b01) begin n_fail++;
      $display("FAIL err_b2b_end got %b%b exp 01", HRESP, HREADY_ERR); end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] exp [3] = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, (i == 0) ? 2'b10 : 2'b11, 3'd2, 3'b100, exp[i]);
      tick();
      n_run++; if (INC_ADDR !== exp[i]) begin n_fail++;
        $display("FAIL wrap8_inc[%0d] got %h exp %h", i, INC_ADDR, exp[i]); end
    end
    idle();
    #2;
    HRESETn = 1'b0;
    #1;
    n_run++; if ({INC_ADDR, HADDR_REG_D1, HADDR_REG_D2, HADDR_REG_D3} !== 128'h0) begin n_fail++;
      $display("FAIL midrst_regs got %h %h %h %h exp 0", INC_ADDR, HADDR_REG_D1, HADDR_REG_D2, HADDR_REG_D3); end
    n_run++; if ({flags, HRESP, HREADY_ERR} !== 6'b000001) begin n_fail++;
      $display("FAIL midrst_ctl got %b%b%b exp 000001", flags, HRESP, HREADY_ERR); end
    tick();
    HRESETn = 1'b1;
    tick();
    drive(1'b1, 2'b10, 3'd2, 3'b001, 32'h8000_1010);
    tick();
    n_run++; if (INC_ADDR !== 32'h8000_1010) begin n_fail++;
      $display("FAIL restart_inc0 got %h exp 80001010", INC_ADDR); end
    drive(1'b1, 2'b11, 3'd1, 3'b001, 32'h8000_1014);
    tick();
    n_run++; if (INC_ADDR !== 32'h8000_1012) begin n_fail++;
      $display("FAIL restart_inc1 got %h exp 80001012", INC_ADDR); end
    idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_incr4();
    test_wrap4_busy();
    test_error();
    test_err_back_to_back();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
